oflow_calc_min_ctrl: RTL
========================

// Module: oflow_calc_min_ctrl
// PURPOSE
//  Sequencer for the two-lane minimum-score calculator. Per object, sweeps N candidates two per step.
//  Per step: runs the similarity-metric pair, pulses the min calculator and waits for its done.
//  After the last step, presents the best two (score, id) results to the score board with a valid/ready handshake.
//  Sits between the core control FSM and the similarity_metric / calc_min / score_board datapath.
// PARAMETERS
//  MAX_CAND    32    maximum candidates per object; CNT_W = $clog2(MAX_CAND+1)
//  TIMEOUT_CYC 255   max cycles waiting for sim_done or done_calc_min before abort
// PORTS
//  clk               in   1          clock
//  reset_N           in   1          synchronous active-low reset
//  start             in   1          begin sweep for one object (sampled only in IDLE)
//  num_cand          in   CNT_W      candidate count, sampled with start; 0..MAX_CAND
//  busy              out  1          high in every state except IDLE
//  sim_start         out  1          1-cycle pulse: similarity metrics evaluate cand_idx_0/1
//  cand_idx_0        out  CNT_W-1..0 candidate index for lane 0 (= 2*pair)
//  cand_idx_1        out  CNT_W-1..0 candidate index for lane 1 (= 2*pair+1)
//  lane1_valid       out  1          lane 1 holds a real candidate; 0 => lane 1 must drive max score
//  sim_done          in   1          both similarity scores/ids stable (level, held until next sim_start)
//  start_score_calc  out  1          1-cycle pulse clearing the min calculator to max score / id 0
//  start_calc_min    out  1          1-cycle pulse to the min calculator
//  done_calc_min     in   1          min calculator finished one step
//  min_score_0/1     in   SCORE_LEN  running minima from the min calculator
//  min_id_0/1        in   ID_LEN     ids of the running minima
//  res_valid         out  1          result held stable until res_ready
//  res_ready         in   1          score board accepts result
//  res_score_0/1     out  SCORE_LEN  captured best / second-best score
//  res_id_0/1        out  ID_LEN     captured ids
//  res_empty         out  1          num_cand was 0; scores are all-ones
//  err_timeout       out  1          sticky; set on abort, cleared by the next accepted start
// BEHAVIOUR
//  Reset: synchronous. On the first clk edge with reset_N==0:
//   - state -> IDLE
//   - all outputs 0, except res_score_0/1, which reset to all-ones
//   - pair counter and watchdog cleared
//   - reset mid-sweep aborts with no res_valid.
//  States and transitions:
//   - IDLE: on start, latch N=num_cand; pair=0; clear err_timeout -> CLEAR.
//   - CLEAR: pulse start_score_calc. N==0 -> OUT with res_empty=1; else -> FETCH.
//   - FETCH: pulse sim_start -> WAIT_SIM.
//   - WAIT_SIM: wait for sim_done -> CMP.
//   - CMP: pulse start_calc_min -> WAIT_CMP.
//   - WAIT_CMP: wait for done_calc_min. On done:
//      last pair (2*pair+2 >= N) -> CAPT;
//      else pair++ -> FETCH.
//   - CAPT: register min_score_*/min_id_* into res_* -> OUT.
//   - OUT: res_valid=1; outputs frozen. Stay until res_ready; on res_ready -> IDLE (res_valid low next cycle).
//  Pulses and latency:
//   - cand_idx_0/1 and lane1_valid are valid from FETCH through WAIT_CMP, changing only on the WAIT_CMP->FETCH edge.
//   - lane1_valid = (2*pair+1 < N). An odd N gives a last step with lane 1 masked.
//   - Control pulses are exactly 1 cycle and never overlap.
//  Min calculator contract: done_calc_min arrives 1 cycle after the start_calc_min pulse.
//  Minimum sweep latency: start -> res_valid with zero-wait sim_done = 2 + 4*ceil(N/2) + 1 cycles.
//  Watchdog:
//   - Counter runs in WAIT_SIM and WAIT_CMP and is cleared on entry to each.
//   - Reaching TIMEOUT_CYC: err_timeout=1 -> IDLE, no res_valid.
//  Boundaries:
//   - start while busy: ignored. res_ready outside OUT: ignored.
//   - N > MAX_CAND: clamped to MAX_CAND.
//   - sim_done or done_calc_min outside its wait state: ignored.
//   - res_ready held high in OUT: 1-cycle res_valid.
//   - start on the same cycle OUT exits to IDLE: ignored; it must be presented in IDLE.
// TESTING
//  - N=4, sim_done/done_calc_min 1-cycle response:
//    2 sim_start pulses (idx 0/1, 2/3), 2 start_calc_min pulses, lane1_valid=1 throughout;
//    res_valid at cycle 2+4*2+1=11 after start.
//  - N=3, scores {9,4,7}:
//    2nd step has cand_idx_0=2, lane1_valid=0;
//    result res_score_0=4 (id of candidate 1), res_score_1=7 (id of candidate 2).
//  - N=0: start_score_calc pulse, no sim_start;
//    res_valid with res_empty=1 and res_score_0/1 all-ones, 2 cycles after start.
//  - sim_done withheld after 2nd sim_start:
//    err_timeout=1 after TIMEOUT_CYC cycles, back to IDLE, no res_valid;
//    the next start clears err_timeout.
//  - res_ready held low 20 cycles:
//    res_* stable, busy=1, a new start is ignored;
//    res_ready=1 -> IDLE next cycle.
//  - reset_N=0 for one cycle mid WAIT_CMP:
//    next cycle busy=0, all pulses 0, res_valid=0;
//    a fresh start then completes normally.

Source files
------------

// File: rtl/oflow_calc_min_ctrl_if.sv
// rtl/oflow_calc_min_ctrl_if.sv - handshake/bus bundle between the min-calc sequencer and its datapath
interface oflow_calc_min_ctrl_if #(
    parameter int MAX_CAND  = 32,
    parameter int SCORE_LEN = 16,
    parameter int ID_LEN    = 8
);
    localparam int CNT_W = $clog2(MAX_CAND + 1);

    logic                 start;
    logic [CNT_W-1:0]     num_cand;
    logic                 busy;
    logic                 sim_start;
    logic [CNT_W-1:0]     cand_idx_0;
    logic [CNT_W-1:0]     cand_idx_1;
    logic                 lane1_valid;
    logic                 sim_done;
    logic                 start_score_calc;
    logic                 start_calc_min;
    logic                 done_calc_min;
    logic [SCORE_LEN-1:0] min_score_0;
    logic [SCORE_LEN-1:0] min_score_1;
    logic [ID_LEN-1:0]    min_id_0;
    logic [ID_LEN-1:0]    min_id_1;
    logic                 res_valid;
    logic                 res_ready;
    logic [SCORE_LEN-1:0] res_score_0;
    logic [SCORE_LEN-1:0] res_score_1;
    logic [ID_LEN-1:0]    res_id_0;
    logic [ID_LEN-1:0]    res_id_1;
    logic                 res_empty;
    logic                 err_timeout;

    // Sequencer side
    modport master (
        input  start, num_cand, sim_done, done_calc_min,
               min_score_0, min_score_1, min_id_0, min_id_1, res_ready,
        output busy, sim_start, cand_idx_0, cand_idx_1, lane1_valid,
               start_score_calc, start_calc_min, res_valid,
               res_score_0, res_score_1, res_id_0, res_id_1, res_empty, err_timeout
    );

    // Core FSM / datapath / score board side
    modport slave (
        output start, num_cand, sim_done, done_calc_min,
               min_score_0, min_score_1, min_id_0, min_id_1, res_ready,
        input  busy, sim_start, cand_idx_0, cand_idx_1, lane1_valid,
               start_score_calc, start_calc_min, res_valid,
               res_score_0, res_score_1, res_id_0, res_id_1, res_empty, err_timeout
    );
endinterface

// File: rtl/oflow_calc_min_ctrl.sv
// rtl/oflow_calc_min_ctrl.sv - per-object two-lane minimum-score sweep sequencer
module oflow_calc_min_ctrl #(
    parameter int MAX_CAND    = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset_N,
    oflow_calc_min_ctrl_if.master  bus
);
    localparam int CNT_W = $clog2(MAX_CAND + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, WAIT_SIM, CMP, WAIT_CMP, CAPT, OUT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  n_lat;
    logic [WD_W-1:0]   wdog;
    logic [CNT_W-1:0]  n_clamped;
    logic              wd_expired;

    // Candidate count clamped to the supported maximum before latching
    always_comb begin
        n_clamped  = (bus.num_cand > CNT_W'(MAX_CAND)) ? CNT_W'(MAX_CAND) : bus.num_cand;
        wd_expired = (wdog == WD_W'(TIMEOUT_CYC - 1));
    end

    // Sweep sequencer; every output is a register, pulses are set on entry to their state
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state                <= IDLE;
            n_lat                <= '0;
            wdog                 <= '0;
            bus.busy             <= 1'b0;
            bus.sim_start        <= 1'b0;
            bus.cand_idx_0       <= '0;
            bus.cand_idx_1       <= '0;
            bus.lane1_valid      <= 1'b0;
            bus.start_score_calc <= 1'b0;
            bus.start_calc_min   <= 1'b0;
            bus.res_valid        <= 1'b0;
            bus.res_score_0      <= '1;
            bus.res_score_1      <= '1;
            bus.res_id_0         <= '0;
            bus.res_id_1         <= '0;
            bus.res_empty        <= 1'b0;
            bus.err_timeout      <= 1'b0;
        end else begin
            bus.sim_start        <= 1'b0;
            bus.start_score_calc <= 1'b0;
            bus.start_calc_min   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_lat                <= n_clamped;
                        bus.cand_idx_0       <= '0;
                        bus.cand_idx_1       <= CNT_W'(1);
                        bus.lane1_valid      <= (CNT_W'(1) < n_clamped);
                        bus.err_timeout      <= 1'b0;
                        bus.res_empty        <= 1'b0;
                        bus.busy             <= 1'b1;
                        bus.start_score_calc <= 1'b1;
                        state                <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (n_lat == '0) begin
                        bus.res_empty   <= 1'b1;
                        bus.res_score_0 <= '1;
                        bus.res_score_1 <= '1;
                        bus.res_id_0    <= '0;
                        bus.res_id_1    <= '0;
                        bus.res_valid   <= 1'b1;
                        state           <= OUT;
                    end else begin
                        bus.sim_start <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    wdog  <= '0;
                    state <= WAIT_SIM;
                end
                WAIT_SIM: begin
                    if (bus.sim_done) begin
                        bus.start_calc_min <= 1'b1;
                        state              <= CMP;
                    end else if (wd_expired) begin
                        bus.err_timeout <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                CMP: begin
                    wdog  <= '0;
                    state <= WAIT_CMP;
                end
                WAIT_CMP: begin
                    if (bus.done_calc_min) begin
                        if (bus.cand_idx_0 + CNT_W'(2) >= n_lat) begin
                            state <= CAPT;
                        end else begin
                            bus.cand_idx_0  <= bus.cand_idx_0 + CNT_W'(2);
                            bus.cand_idx_1  <= bus.cand_idx_1 + CNT_W'(2);
                            bus.lane1_valid <= (bus.cand_idx_1 + CNT_W'(2) < n_lat);
                            bus.sim_start   <= 1'b1;
                            state           <= FETCH;
                        end
                    end else if (wd_expired) begin
                        bus.err_timeout <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                CAPT: begin
                    bus.res_score_0 <= bus.min_score_0;
                    bus.res_score_1 <= bus.min_score_1;
                    bus.res_id_0    <= bus.min_id_0;
                    bus.res_id_1    <= bus.min_id_1;
                    bus.res_valid   <= 1'b1;
                    state           <= OUT;
                end
                OUT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
